// File: rtl/reg_writeback_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: primary and secondary
// writeback sources on one side, the register-file write port on the other.
interface reg_writeback_arbiter_if;
   logic        p_we;
   logic [4:0]  p_addr;
   logic [31:0] p_data;
   logic        p_stall;
   logic        s_valid;
   logic        s_ready;
   logic [4:0]  s_addr;
   logic [31:0] s_data;
   logic        we3;
   logic [4:0]  a3;
   logic [31:0] wd3;

   modport master (
      output p_we, p_addr, p_data, s_valid, s_addr, s_data,
      input  p_stall, s_ready, we3, a3, wd3
   );

   modport slave (
      input  p_we, p_addr, p_data, s_valid, s_addr, s_data,
      output p_stall, s_ready, we3, a3, wd3
   );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Merges in-order primary writeback and FIFO-buffered secondary writeback onto
// the register-file write port. Define WB_FWD_EN to build the forwarding-data outputs.
module reg_writeback_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   reg_writeback_arbiter_if.slave   bus,
   output logic [$clog2(DEPTH):0]   q_count,
   input  logic [4:0]               rd_a1,
   input  logic [4:0]               rd_a2,
   output logic                     pend1,
   output logic                     pend2,
   output logic [31:0]              fwd1_data,
   output logic [31:0]              fwd2_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT) + 1;

   logic [4:0]    r_addr [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve;
   logic          r_stall;
   logic          r_we3;
   logic [4:0]    r_a3;
   logic [31:0]   r_wd3;

   logic w_empty, w_full, w_push, w_prim, w_pop;
   logic w_qhit1, w_qhit2;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   // Address-0 pushes complete the handshake but are dropped.
   assign w_push  = bus.s_valid && !w_full && (bus.s_addr != 5'd0);
   assign w_prim  = bus.p_we && (bus.p_addr != 5'd0) && !r_stall;
   // A forced pop (stalled) beats the primary; otherwise the FIFO only uses idle slots.
   assign w_pop   = !w_empty && (r_stall || !w_prim);

   assign bus.s_ready = !w_full;
   assign bus.p_stall = r_stall;
   assign bus.we3     = r_we3;
   assign bus.a3      = r_a3;
   assign bus.wd3     = r_wd3;
   assign q_count     = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wptr] <= bus.s_addr;
         r_data[r_wptr] <= bus.s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_stall  <= 1'b0;
         r_we3    <= 1'b0;
         r_a3     <= 5'd0;
         r_wd3    <= 32'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_empty || w_pop) r_starve <= '0;
         else                  r_starve <= r_starve + 1'b1;

         if (w_pop)
            r_stall <= 1'b0;
         else if (!w_empty && (r_starve == SW'(STARVE_LIMIT - 1)))
            r_stall <= 1'b1;

         r_we3 <= w_pop || w_prim;
         if (w_pop) begin
            r_a3  <= r_addr[r_rptr];
            r_wd3 <= r_data[r_rptr];
         end else if (w_prim) begin
            r_a3  <= bus.p_addr;
            r_wd3 <= bus.p_data;
         end
      end
   end

`ifdef WB_FWD_EN
   logic [31:0] w_qdat1, w_qdat2;

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin : scan_fwd
      logic [AW-1:0] w_idx;
      w_qhit1 = 1'b0;
      w_qhit2 = 1'b0;
      w_qdat1 = 32'd0;
      w_qdat2 = 32'd0;
      w_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + AW'(k);
         if (CW'(k) < r_count) begin
            if (r_addr[w_idx] == rd_a1) begin
               w_qhit1 = 1'b1;
               w_qdat1 = r_data[w_idx];
            end
            if (r_addr[w_idx] == rd_a2) begin
               w_qhit2 = 1'b1;
               w_qdat2 = r_data[w_idx];
            end
         end
      end
   end

   assign fwd1_data = w_qhit1 ? w_qdat1 : ((r_we3 && r_a3 == rd_a1) ? r_wd3 : 32'd0);
   assign fwd2_data = w_qhit2 ? w_qdat2 : ((r_we3 && r_a3 == rd_a2) ? r_wd3 : 32'd0);
`else
   always_comb begin : scan_pend
      logic [AW-1:0] w_idx;
      w_qhit1 = 1'b0;
      w_qhit2 = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + AW'(k);
         if (CW'(k) < r_count) begin
            if (r_addr[w_idx] == rd_a1) w_qhit1 = 1'b1;
            if (r_addr[w_idx] == rd_a2) w_qhit2 = 1'b1;
         end
      end
   end

   assign fwd1_data = 32'd0;
   assign fwd2_data = 32'd0;
`endif

   assign pend1 = (rd_a1 != 5'd0) && (w_qhit1 || (r_we3 && r_a3 == rd_a1));
   assign pend2 = (rd_a2 != 5'd0) && (w_qhit2 || (r_we3 && r_a3 == rd_a2));
endmodule
